// File: rtl/dsp_slice.sv
// dsp_slice: DSP48A1-style D+/-B pre-adder, 18x18 multiplier and 48-bit post-adder; a/b/d->p 4 edges with all regs, no backpressure (per-stage ce only).
// Define DSP_SLICE_PARAM_CHECK_EN to raise $error at simulation start for illegal *REG / CARRYINSEL / B_INPUT values.

module dsp_slice_stage #(
    parameter int W  = 18,
    parameter int EN = 1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_ce) begin
            r_q <= i_d;
        end
    end

    assign o_q = (EN != 0) ? r_q : i_d;
endmodule

module dsp_slice #(
    parameter int    A0REG       = 1,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 1,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        clk,
    input  logic        rsta,
    input  logic        rstb,
    input  logic        rstc,
    input  logic        rstd,
    input  logic        rstm,
    input  logic        rstp,
    input  logic        rstcarryin,
    input  logic        rstopmode,
    input  logic [7:0]  opmode,
    input  logic [17:0] a,
    input  logic [17:0] b,
    input  logic [17:0] d,
    input  logic [47:0] c,
    input  logic [17:0] bcin,
    input  logic [47:0] pcin,
    input  logic        carryin,
    input  logic        cea,
    input  logic        ceb,
    input  logic        cec,
    input  logic        ced,
    input  logic        cem,
    input  logic        cep,
    input  logic        cecarryin,
    input  logic        ceopmode,
    output logic [17:0] bcout,
    output logic [47:0] pcout,
    output logic [47:0] p,
    output logic [35:0] m,
    output logic        carryout,
    output logic        carryoutf
);
    localparam bit CYI_FROM_PIN = (CARRYINSEL == "CARRYIN");
    localparam bit B_DIRECT     = (B_INPUT == "DIRECT");
    localparam bit B_CASCADE    = (B_INPUT == "CASCADE");

`ifdef DSP_SLICE_PARAM_CHECK_EN
    initial begin
        if (!(A0REG inside {0, 1}))       $error("dsp_slice: A0REG=%0d not 0/1", A0REG);
        if (!(A1REG inside {0, 1}))       $error("dsp_slice: A1REG=%0d not 0/1", A1REG);
        if (!(B0REG inside {0, 1}))       $error("dsp_slice: B0REG=%0d not 0/1", B0REG);
        if (!(B1REG inside {0, 1}))       $error("dsp_slice: B1REG=%0d not 0/1", B1REG);
        if (!(CREG inside {0, 1}))        $error("dsp_slice: CREG=%0d not 0/1", CREG);
        if (!(DREG inside {0, 1}))        $error("dsp_slice: DREG=%0d not 0/1", DREG);
        if (!(MREG inside {0, 1}))        $error("dsp_slice: MREG=%0d not 0/1", MREG);
        if (!(PREG inside {0, 1}))        $error("dsp_slice: PREG=%0d not 0/1", PREG);
        if (!(CARRYINREG inside {0, 1}))  $error("dsp_slice: CARRYINREG=%0d not 0/1", CARRYINREG);
        if (!(CARRYOUTREG inside {0, 1})) $error("dsp_slice: CARRYOUTREG=%0d not 0/1", CARRYOUTREG);
        if (!(OPMODEREG inside {0, 1}))   $error("dsp_slice: OPMODEREG=%0d not 0/1", OPMODEREG);
        if (!(CARRYINSEL == "CARRYIN" || CARRYINSEL == "OPMODE5"))
            $error("dsp_slice: CARRYINSEL=%s unsupported", CARRYINSEL);
        if (!(B_DIRECT || B_CASCADE))
            $error("dsp_slice: B_INPUT=%s unsupported", B_INPUT);
    end
`else
`endif

    logic [7:0]  w_opm;
    logic [17:0] w_a0, w_a1, w_b0_in, w_b0, w_b1_in, w_b1, w_d, w_pre;
    logic [35:0] w_mult, w_m;
    logic [47:0] w_c, w_x, w_z, w_p;
    logic        w_cin_src, w_cyi, w_cout;
    logic [48:0] w_post;
    logic [47:0] r_p;
    logic        r_cout;

    dsp_slice_stage #(.W(8), .EN(OPMODEREG)) u_opmode (
        .clk(clk), .i_rst(rstopmode), .i_ce(ceopmode), .i_d(opmode), .o_q(w_opm)
    );

    dsp_slice_stage #(.W(18), .EN(A0REG)) u_a0 (
        .clk(clk), .i_rst(rsta), .i_ce(cea), .i_d(a), .o_q(w_a0)
    );
    dsp_slice_stage #(.W(18), .EN(A1REG)) u_a1 (
        .clk(clk), .i_rst(rsta), .i_ce(cea), .i_d(w_a0), .o_q(w_a1)
    );

    assign w_b0_in = B_DIRECT ? b : (B_CASCADE ? bcin : 18'd0);

    dsp_slice_stage #(.W(18), .EN(B0REG)) u_b0 (
        .clk(clk), .i_rst(rstb), .i_ce(ceb), .i_d(w_b0_in), .o_q(w_b0)
    );
    dsp_slice_stage #(.W(18), .EN(DREG)) u_d (
        .clk(clk), .i_rst(rstd), .i_ce(ced), .i_d(d), .o_q(w_d)
    );

    // Pre-adder wraps at 18 bits, matching the primitive it models.
    assign w_pre   = w_opm[6] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_in = w_opm[4] ? w_pre : w_b0;

    dsp_slice_stage #(.W(18), .EN(B1REG)) u_b1 (
        .clk(clk), .i_rst(rstb), .i_ce(ceb), .i_d(w_b1_in), .o_q(w_b1)
    );

    assign w_mult = w_a1 * w_b1;

    dsp_slice_stage #(.W(36), .EN(MREG)) u_m (
        .clk(clk), .i_rst(rstm), .i_ce(cem), .i_d(w_mult), .o_q(w_m)
    );
    dsp_slice_stage #(.W(48), .EN(CREG)) u_c (
        .clk(clk), .i_rst(rstc), .i_ce(cec), .i_d(c), .o_q(w_c)
    );

    // Carry source is taken ahead of the OPMODE register so it pipelines once, through CYI.
    assign w_cin_src = CYI_FROM_PIN ? carryin : opmode[5];

    dsp_slice_stage #(.W(1), .EN(CARRYINREG)) u_cyi (
        .clk(clk), .i_rst(rstcarryin), .i_ce(cecarryin), .i_d(w_cin_src), .o_q(w_cyi)
    );

    always_comb begin
        w_x = '0;
        case (w_opm[1:0])
            2'd0: w_x = '0;
            2'd1: w_x = {12'd0, w_m};
            2'd2: w_x = r_p;
            2'd3: w_x = {w_d[11:0], w_a1, w_b1};
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (w_opm[3:2])
            2'd0: w_z = '0;
            2'd1: w_z = pcin;
            2'd2: w_z = r_p;
            2'd3: w_z = w_c;
            default: w_z = '0;
        endcase
    end

    assign w_post = w_opm[7] ? ({1'b0, w_z} - ({1'b0, w_x} + {48'd0, w_cyi}))
                             : ({1'b0, w_z} + {1'b0, w_x} + {48'd0, w_cyi});
    assign w_cout = w_post[48];

    // Accumulator feedback always reads the P register, so PREG=0 cannot form a comb loop.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            r_p <= '0;
        end else if (cep) begin
            r_p <= w_post[47:0];
        end
    end

    always_ff @(posedge clk or posedge rstcarryin) begin
        if (rstcarryin) begin
            r_cout <= 1'b0;
        end else if (cecarryin) begin
            r_cout <= w_cout;
        end
    end

    assign w_p       = (PREG != 0) ? r_p : w_post[47:0];
    assign p         = w_p;
    assign pcout     = w_p;
    assign m         = w_m;
    assign bcout     = w_b1;
    assign carryout  = (CARRYOUTREG != 0) ? r_cout : w_cout;
    assign carryoutf = carryout;
endmodule

// File: tb/tb_dsp_slice.sv
// Directed bench for dsp_slice with every pipeline register enabled.
module tb_dsp_slice;
    logic        clk = 1'b0;
    logic        rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode;
    logic [7:0]  opmode;
    logic [17:0] a, b, d, bcin;
    logic [47:0] c, pcin;
    logic        carryin;
    logic        cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode;
    logic [17:0] bcout;
    logic [47:0] pcout, p;
    logic [35:0] m;
    logic        carryout, carryoutf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsp_slice dut (
        .clk(clk), .rsta(rsta), .rstb(rstb), .rstc(rstc), .rstd(rstd), .rstm(rstm),
        .rstp(rstp), .rstcarryin(rstcarryin), .rstopmode(rstopmode), .opmode(opmode),
        .a(a), .b(b), .d(d), .c(c), .bcin(bcin), .pcin(pcin), .carryin(carryin),
        .cea(cea), .ceb(ceb), .cec(cec), .ced(ced), .cem(cem), .cep(cep),
        .cecarryin(cecarryin), .ceopmode(ceopmode), .bcout(bcout), .pcout(pcout),
        .p(p), .m(m), .carryout(carryout), .carryoutf(carryoutf)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        {rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode} = 8'hFF;
        {cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode} = 8'hFF;
        a = 18'd10; b = 18'd20; d = 18'd30; c = 48'd40;
        bcin = 18'd0; pcin = 48'd0; carryin = 1'b0; opmode = 8'hF0;
        tick(10);
        checks++; if (bcout !== 18'd0) begin failures++; $display("FAIL reset_bcout got=%0d exp=0", bcout); end
        checks++; if (pcout !== 48'd0) begin failures++; $display("FAIL reset_pcout got=%0d exp=0", pcout); end
        checks++; if (p !== 48'd0) begin failures++; $display("FAIL reset_p got=%0d exp=0", p); end
        checks++; if (m !== 36'd0) begin failures++; $display("FAIL reset_m got=%0d exp=0", m); end
        checks++; if (carryout !== 1'b0) begin failures++; $display("FAIL reset_carryout got=%0b exp=0", carryout); end
        checks++; if (carryoutf !== 1'b0) begin failures++; $display("FAIL reset_carryoutf got=%0b exp=0", carryoutf); end
        {rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode} = 8'h00;
    endtask

    task automatic test_preadd_mult();
        opmode = 8'h10;
        tick(5);
        checks++; if (m !== 36'd500) begin failures++; $display("FAIL preadd_m got=%0d exp=500", m); end
        checks++; if (p !== 48'd0) begin failures++; $display("FAIL preadd_p got=%0d exp=0", p); end
        checks++; if (bcout !== 18'd50) begin failures++; $display("FAIL preadd_bcout got=%0d exp=50", bcout); end
    endtask

    task automatic test_mult_add_c();
        opmode = 8'h1D;
        tick(5);
        checks++; if (m !== 36'd500) begin failures++; $display("FAIL madd_m got=%0d exp=500", m); end
        checks++; if (p !== 48'd540) begin failures++; $display("FAIL madd_p got=%0d exp=540", p); end
        checks++; if (pcout !== 48'd540) begin failures++; $display("FAIL madd_pcout got=%0d exp=540", pcout); end
        checks++; if (carryout !== 1'b0) begin failures++; $display("FAIL madd_carryout got=%0b exp=0", carryout); end
    endtask

    task automatic test_c_latency();
        c = 48'd100;
        tick(1);
        checks++; if (p !== 48'd540) begin failures++; $display("FAIL clat_edge1 got=%0d exp=540", p); end
        tick(1);
        checks++; if (p !== 48'd600) begin failures++; $display("FAIL clat_edge2 got=%0d exp=600", p); end
        c = 48'd40;
        tick(2);
    endtask

    task automatic test_z_c();
        opmode = 8'h1C;
        tick(3);
        checks++; if (p !== 48'd40) begin failures++; $display("FAIL zc_p got=%0d exp=40", p); end
        checks++; if (m !== 36'd500) begin failures++; $display("FAIL zc_m got=%0d exp=500", m); end
    endtask

    task automatic test_bypass_preadd();
        opmode = 8'h00;
        tick(5);
        checks++; if (m !== 36'd200) begin failures++; $display("FAIL bypass_m got=%0d exp=200", m); end
        checks++; if (p !== 48'd0) begin failures++; $display("FAIL bypass_p got=%0d exp=0", p); end
        checks++; if (bcout !== 18'd20) begin failures++; $display("FAIL bypass_bcout got=%0d exp=20", bcout); end
    endtask

    task automatic test_mux_x3_pcin();
        logic [47:0] exp_cat;
        exp_cat = {12'd30, 18'd10, 18'd20};
        opmode = 8'h03;
        tick(5);
        checks++; if (p !== exp_cat) begin failures++; $display("FAIL x3_concat got=%h exp=%h", p, exp_cat); end
        pcin = 48'd1000;
        opmode = 8'h05;
        tick(5);
        checks++; if (p !== 48'd1200) begin failures++; $display("FAIL z_pcin got=%0d exp=1200", p); end
        pcin = 48'd0;
    endtask

    task automatic test_subtract();
        c = 48'd1000;
        opmode = 8'hBD;
        tick(5);
        checks++; if (p !== 48'd499) begin failures++; $display("FAIL sub_cin_p got=%0d exp=499", p); end
        checks++; if (carryout !== 1'b0) begin failures++; $display("FAIL sub_cin_carryout got=%0b exp=0", carryout); end
        // Pre-subtract with the pre-adder selected into B1: (30-20)*10.
        opmode = 8'hDD;
        tick(5);
        checks++; if (m !== 36'd100) begin failures++; $display("FAIL presub_m got=%0d exp=100", m); end
        checks++; if (p !== 48'd900) begin failures++; $display("FAIL presub_p got=%0d exp=900", p); end
        // Bit 4 clear: pre-subtract result is computed but B1 takes B0.
        opmode = 8'hCD;
        tick(5);
        checks++; if (m !== 36'd200) begin failures++; $display("FAIL cd_m got=%0d exp=200", m); end
        checks++; if (p !== 48'd800) begin failures++; $display("FAIL cd_p got=%0d exp=800", p); end
    endtask

    task automatic test_borrow();
        c = 48'd40;
        opmode = 8'h9D;
        tick(5);
        checks++; if (p !== 48'hFFFF_FFFF_FE34) begin failures++; $display("FAIL borrow_p got=%h exp=fffffffffe34", p); end
        checks++; if (carryout !== 1'b1) begin failures++; $display("FAIL borrow_carryout got=%0b exp=1", carryout); end
        checks++; if (carryoutf !== 1'b1) begin failures++; $display("FAIL borrow_carryoutf got=%0b exp=1", carryoutf); end
    endtask

    task automatic test_async_reset();
        opmode = 8'h10;
        tick(5);
        rstm = 1'b1;
        #1;
        checks++; if (m !== 36'd0) begin failures++; $display("FAIL async_rstm got=%0d exp=0", m); end
        rstm = 1'b0;
        tick(1);
        checks++; if (m !== 36'd500) begin failures++; $display("FAIL async_resume got=%0d exp=500", m); end
    endtask

    task automatic test_ce_hold();
        cea = 1'b0;
        a = 18'd3;
        tick(5);
        checks++; if (m !== 36'd500) begin failures++; $display("FAIL ce_hold got=%0d exp=500", m); end
        cea = 1'b1;
        tick(2);
        checks++; if (m !== 36'd500) begin failures++; $display("FAIL ce_lat_edge2 got=%0d exp=500", m); end
        tick(1);
        checks++; if (m !== 36'd150) begin failures++; $display("FAIL ce_lat_edge3 got=%0d exp=150", m); end
        a = 18'd10;
        tick(3);
    endtask

    task automatic test_accumulate();
        cep = 1'b0;
        opmode = 8'h19;
        tick(4);
        rstp = 1'b1;
        #1;
        checks++; if (p !== 48'd0) begin failures++; $display("FAIL acc_clear got=%0d exp=0", p); end
        rstp = 1'b0;
        cep = 1'b1;
        tick(1);
        checks++; if (p !== 48'd500) begin failures++; $display("FAIL acc_1 got=%0d exp=500", p); end
        tick(1);
        checks++; if (p !== 48'd1000) begin failures++; $display("FAIL acc_2 got=%0d exp=1000", p); end
        tick(2);
        checks++; if (p !== 48'd2000) begin failures++; $display("FAIL acc_4 got=%0d exp=2000", p); end
    endtask

    initial begin
        test_reset();
        test_preadd_mult();
        test_mult_add_c();
        test_c_latency();
        test_z_c();
        test_bypass_preadd();
        test_mux_x3_pcin();
        test_subtract();
        test_borrow();
        test_async_reset();
        test_ce_hold();
        test_accumulate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
